// File: rtl/fetch_sequencer_if.sv
// ============================================================================
//  Module   : fetch_sequencer_if
//  Purpose  : Instruction-memory request/response bundle used by the fetch
//             sequencer (master) and the instruction memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
    parameter int N = 64
) ();
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic [31:0]  imem_rdata;

    // Requester side: drives the request, receives the completion and data
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Memory side: sees the request, returns completion and data
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : LEGv8 fetch stage for variable-latency instruction memory.
//             Owns the PC, keeps one request outstanding at a time, delivers
//             instructions through an output register plus a one-entry skid
//             buffer, handles decode stalls, branch redirects (squashing an
//             in-flight fetch) and raises a sticky memory-timeout flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int          N        = 64,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int          MAX_WAIT = 15
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            PCSrc_F,
    input  wire logic [N-1:0]    PCBranch_F,
    input  wire logic            stall_D,
    fetch_sequencer_if.master    imem,
    output logic                 valid_F,
    output logic [31:0]          instr_F,
    output logic [N-1:0]         pc_F,
    output logic                 fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [7:0]   c_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [N-1:0] c_PC_STEP  = N'(4);

    state_t       r_state;
    logic [N-1:0] r_pc;
    logic         r_valid;
    logic [31:0]  r_instr;
    logic [N-1:0] r_pc_out;
    logic         r_skid_valid;
    logic [31:0]  r_skid_instr;
    logic [N-1:0] r_skid_pc;
    logic         r_squash;
    logic [N-1:0] r_target;
    logic [7:0]   r_wait_cnt;
    logic         r_err;

    logic         w_consume;
    logic         w_out_free;

    // Decode takes the presented instruction on this edge
    assign w_consume  = r_valid && !stall_D;
    // Output register can accept a new word this edge (skid must be drained first
    // so that program order is preserved)
    assign w_out_free = (!r_valid || w_consume) && !r_skid_valid;

    // Request is driven straight from state/PC registers, so the address is
    // stable for as long as the request is held
    assign imem.imem_req  = (r_state == S_REQ);
    assign imem.imem_addr = r_pc;

    assign valid_F   = r_valid;
    assign instr_F   = r_instr;
    assign pc_F      = r_pc_out;
    assign fetch_err = r_err;

    // Fetch control: state, PC, output register, skid buffer, squash and timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_pc_out     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_squash     <= 1'b0;
            r_target     <= '0;
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            // A consumed word leaves the output unless something refills it below
            if (w_consume) begin
                r_valid <= 1'b0;
            end

            if (PCSrc_F) begin
                // Everything fetched before the redirect is stale
                r_valid      <= 1'b0;
                r_skid_valid <= 1'b0;
                if (r_state != S_REQ || imem.imem_ready) begin
                    // Nothing in flight (or it completes now and is dropped)
                    r_pc       <= PCBranch_F;
                    r_squash   <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= S_REQ;
                end else begin
                    // Request still pending: address must stay put, so remember
                    // where to go once the stale response returns
                    r_squash <= 1'b1;
                    r_target <= PCBranch_F;
                    if (r_wait_cnt != 8'hFF) begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                    if (r_wait_cnt + 8'd1 >= c_MAX_WAIT) begin
                        r_err <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_REQ;
                    end
                    S_REQ: begin
                        if (imem.imem_ready) begin
                            r_wait_cnt <= '0;
                            if (r_squash) begin
                                // Stale response: drop it and chase the target
                                r_pc     <= r_target;
                                r_squash <= 1'b0;
                            end else begin
                                r_pc <= r_pc + c_PC_STEP;
                                if (w_out_free) begin
                                    r_valid  <= 1'b1;
                                    r_instr  <= imem.imem_rdata;
                                    r_pc_out <= r_pc;
                                end else begin
                                    r_skid_valid <= 1'b1;
                                    r_skid_instr <= imem.imem_rdata;
                                    r_skid_pc    <= r_pc;
                                    r_state      <= S_FULL;
                                end
                            end
                        end else begin
                            if (r_wait_cnt != 8'hFF) begin
                                r_wait_cnt <= r_wait_cnt + 8'd1;
                            end
                            if (r_wait_cnt + 8'd1 >= c_MAX_WAIT) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_FULL: begin
                        // No new request until the skid word moves to the output
                        if (w_consume) begin
                            r_valid      <= 1'b1;
                            r_instr      <= r_skid_instr;
                            r_pc_out     <= r_skid_pc;
                            r_skid_valid <= 1'b0;
                            r_state      <= S_REQ;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the fetch stage of the LEGv8 pipeline when instruction memory has variable latency. Owns the PC, issues one outstanding request at a time to the instruction memory and presents fetched instructions to decode through an output register plus a one-entry skid buffer. Handles decode stalls and branch redirects, including squashing an in-flight fetch, and flags a memory timeout.

Parameters:
N, 64, PC/address width
RESET_PC, 64'd0, first fetch address after reset
MAX_WAIT, 15, wait cycles on one request before fetch_err sets (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = in reset
PCSrc_F  in  1  branch redirect, one-cycle pulse
PCBranch_F  in  N  redirect target, valid when PCSrc_F=1
stall_D  in  1  decode cannot take an instruction this cycle
imem_req  out  1  request valid; held until imem_ready
imem_addr  out  N  request address; stable while imem_req=1
imem_ready  in  1  request done this cycle; imem_rdata valid
imem_rdata  in  32  instruction word
valid_F  out  1  instr_F/pc_F hold an instruction
instr_F  out  32  fetched instruction
pc_F  out  N  address of instr_F
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, valid_F=0, instr_F=0, pc_F=0, skid empty, squash=0, wait_cnt=0, fetch_err=0, imem_req=0.
- States: IDLE, REQ, FULL. imem_req=1 only in REQ. imem_addr=pc at all times.
- IDLE -> REQ on the first edge after reset release. First request goes out 1 cycle after release.
- Consume: the instruction is taken at an edge with valid_F=1 and stall_D=0.
- REQ, imem_ready=1, no squash, no PCSrc_F:
  - pc<=pc+4, mod 2^N.
  - If the output is free (valid_F=0, or it is being consumed) and the skid is empty: load instr_F/pc_F, valid_F<=1.
  - Otherwise write to the skid.
  - Next state: FULL if the skid is now full, else REQ (back-to-back requests allowed).
- REQ, imem_ready=0: hold imem_req and addr, wait_cnt++. When wait_cnt reaches MAX_WAIT, fetch_err<=1 and stays 1 until reset. Keep waiting. wait_cnt clears on imem_ready.
- FULL: no request. When output is consumed: skid -> output (valid_F stays 1), skid empty, -> REQ.
- Redirect (PCSrc_F=1, any state):
  - Next edge: valid_F<=0, skid emptied.
  - If no request is outstanding, or imem_ready=1 this cycle: discard any response; pc<=PCBranch_F; next state REQ. The first redirected request is asserted the next cycle.
  - If a request is outstanding with imem_ready=0: squash<=1, target<=PCBranch_F. imem_addr stays unchanged, because address must stay stable.
- squash=1 and imem_ready=1: discard the response, pc<=target, squash<=0, stay REQ. A new request to target follows next cycle.
- Redirect while squash=1: target overwritten. Latest wins.
- PCBranch_F low bits are passed through unaltered. No alignment check.
- Ordering: decode sees instructions strictly in PC order. No instruction fetched before a redirect is delivered after it.
- Reset mid-request: state and buffers clear immediately. The outstanding memory request is abandoned.

Test Plan:
- Reset release, imem_ready tied 1, stall_D=0, imem_rdata=addr-derived: imem_addr 0,4,8,... one per cycle. valid_F=1 from cycle 2. pc_F=0,4,8 with matching instr_F.
- stall_D=1 for 4 cycles mid-stream: valid_F held, pc_F frozen (e.g. 0x8). Skid holds 0xC, state FULL, imem_req=0. On release, 0x8 then 0xC delivered, then request to 0x10 resumes. No gaps or duplicates.
- imem_ready delayed 3 cycles on addr 0x4: imem_req/imem_addr=0x4 held stable for 4 cycles. valid_F=0 once 0x0 consumed. fetch_err stays 0.
- PCSrc_F=1, PCBranch_F=0x100 while request to 0x20 waits 2 more cycles: 0x20 response discarded. Next request is 0x100. valid_F=0 until 0x100 delivered. 0x20 never reaches decode.
- Two redirects (0x100, then 0x200) during one squashed wait: next request is 0x200, not 0x100.
- imem_ready held 0 for 20 cycles, MAX_WAIT=15: fetch_err=1 at wait_cnt=15 and stays 1 after data returns. reset=0 asynchronously clears it and all outputs with no clock edge.
